// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller:
// default geometry, the NOP fill word and the controller state encoding.
package imem_load_ctrl_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DATA_W = 32;

  // Word written over the whole memory before a new program streams in
  localparam logic [IMEM_DATA_W-1:0] NOP_WORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Reprogramming sequencer for the instruction memory: holds the CPU, zero-fills
// every word, streams the loader's program from word 0, then releases the CPU.
import imem_load_ctrl_pkg::*;

module imem_load_ctrl #(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              ld_busy,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ld_ready_q, ld_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              ld_busy_q, ld_busy_d;
  logic [CNT_W-1:0]  ld_count_q, ld_count_d;
  logic              ld_err_q, ld_err_d;

  logic              cnt_full;
  logic              handshake;

  // cnt_q is the sweep address in CLEAR and the accepted-word count in LOAD
  assign cnt_full  = (cnt_q == CNT_W'(DEPTH));
  assign handshake = ld_valid & ld_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ld_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b1;
      ld_busy_q   <= 1'b0;
      ld_count_q  <= '0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_ready_q  <= ld_ready_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      ld_busy_q   <= ld_busy_d;
      ld_count_q  <= ld_count_d;
      ld_err_q    <= ld_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_run_d   = cpu_run_q;
    ld_busy_d   = ld_busy_q;
    ld_count_d  = ld_count_q;
    ld_err_d    = ld_err_q;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (state_q == ST_IDLE) begin
          cpu_run_d = 1'b1;
          ld_busy_d = 1'b0;
        end
        // A start request wins over any loader word presented alongside it
        if (ld_start) begin
          state_d     = ST_CLEAR;
          cnt_d       = CNT_W'(1);
          mem_we_d    = 1'b1;
          mem_waddr_d = '0;
          mem_wdata_d = DATA_W'(NOP_WORD);
          cpu_run_d   = 1'b0;
          ld_busy_d   = 1'b1;
          ld_count_d  = '0;
          ld_err_d    = 1'b0;
        end
      end

      ST_CLEAR: begin
        if (cnt_full) begin
          state_d    = ST_LOAD;
          cnt_d      = '0;
          ld_ready_d = 1'b1;
        end else begin
          mem_we_d    = 1'b1;
          mem_waddr_d = cnt_q[ADDR_W-1:0];
          mem_wdata_d = DATA_W'(NOP_WORD);
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end

      ST_LOAD: begin
        ld_ready_d = 1'b1;
        if (handshake) begin
          if (cnt_full) begin
            // Program longer than the memory: drop the word and park in ERR
            state_d    = ST_ERR;
            ld_ready_d = 1'b0;
            ld_busy_d  = 1'b0;
            ld_err_d   = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_waddr_d = cnt_q[ADDR_W-1:0];
            mem_wdata_d = ld_data;
            cnt_d       = cnt_q + CNT_W'(1);
            ld_count_d  = cnt_q + CNT_W'(1);
            if (ld_last) begin
              state_d    = ST_DONE;
              ld_ready_d = 1'b0;
            end
          end
        end
      end

      ST_DONE: begin
        // First DONE cycle carries the final write; release the CPU after a quiet cycle
        if (!mem_we_q) begin
          state_d   = ST_IDLE;
          cpu_run_d = 1'b1;
          ld_busy_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign ld_ready  = ld_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign ld_busy   = ld_busy_q;
  assign ld_count  = ld_count_q;
  assign ld_err    = ld_err_q;

endmodule
